// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller and the display decoder:
// the encoded FSM state, the fail counter width and a state-class helper.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4,
    ST_LOCKOUT  = 3'd5,
    ST_CHECK    = 3'd6,
    ST_DECIDE   = 3'd7
  } state_t;

  localparam int FAIL_W = 2;
  localparam logic [FAIL_W-1:0] FAIL_SAT = '1;

  function automatic logic is_armed(input state_t s);
    return s inside {ST_ARMED, ST_ENTRY, ST_ALARM, ST_LOCKOUT};
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the EXIT, ENTRY and LOCKOUT phases.
// Load wins over enable; the count parks at zero instead of wrapping.
module alarm_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_controller.sv
// Top-level alarm sequencing FSM: arming delays, code checks through the
// external validation block, wrong-attempt escalation and status outputs.
module alarm_controller import alarm_pkg::*; #(
  parameter int EXIT_DELAY     = 8,
  parameter int ENTRY_DELAY    = 8,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              arm_req,
  input  logic              code_submit,
  input  logic              sensor_trip,
  input  logic              correct_signal,
  output logic              validate_en,
  output logic              armed,
  output logic              alarm,
  output logic              exit_pending,
  output logic [FAIL_W-1:0] fail_count,
  output logic [2:0]        state
);

  state_t            st_q, st_d, ret_q, ret_d, shown_d;
  logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0]  tmr_val;

  alarm_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    st_d     = st_q;
    ret_d    = ret_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    fail_inc = (fail_q == FAIL_SAT) ? fail_q : fail_q + FAIL_W'(1);
    case (st_q)
      ST_DISARMED: if (arm_req) begin
        st_d     = ST_EXIT;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(EXIT_DELAY - 1);
      end
      // Submission beats expiry; the timer is left untouched so the phase
      // resumes with its remaining count after a wrong code.
      ST_EXIT, ST_ENTRY: begin
        if (code_submit) begin
          st_d  = ST_CHECK;
          ret_d = st_q;
        end else if (tmr_zero)
          st_d = (st_q == ST_EXIT) ? ST_ARMED : ST_ALARM;
        else
          tmr_en = 1'b1;
      end
      ST_ARMED: begin
        if (code_submit) begin
          st_d  = ST_CHECK;
          ret_d = ST_ARMED;
        end else if (sensor_trip) begin
          st_d     = ST_ENTRY;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(ENTRY_DELAY - 1);
        end
      end
      ST_ALARM: if (code_submit) begin
        st_d  = ST_CHECK;
        ret_d = ST_ALARM;
      end
      ST_LOCKOUT: begin
        if (tmr_zero) st_d = ST_ALARM;
        else          tmr_en = 1'b1;
      end
      ST_CHECK: st_d = ST_DECIDE;
      // correct_signal is only trustworthy here, one cycle after validate_en.
      ST_DECIDE: begin
        if (correct_signal) begin
          st_d     = ST_DISARMED;
          ret_d    = ST_DISARMED;
          fail_d   = '0;
          tmr_load = 1'b1;
        end else begin
          fail_d = fail_inc;
          if (int'(fail_inc) >= MAX_TRIES) begin
            st_d     = ST_LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(LOCKOUT_CYCLES - 1);
          end else
            st_d = ret_q;
        end
      end
      default: st_d = ST_DISARMED;
    endcase
    shown_d = (st_d == ST_CHECK || st_d == ST_DECIDE) ? ret_d : st_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st_q         <= ST_DISARMED;
      ret_q        <= ST_DISARMED;
      fail_q       <= '0;
      validate_en  <= 1'b0;
      armed        <= 1'b0;
      alarm        <= 1'b0;
      exit_pending <= 1'b0;
    end else begin
      st_q         <= st_d;
      ret_q        <= ret_d;
      fail_q       <= fail_d;
      validate_en  <= (st_d == ST_CHECK);
      armed        <= is_armed(shown_d);
      alarm        <= (st_d == ST_ALARM) || (st_d == ST_LOCKOUT);
      exit_pending <= (shown_d == ST_EXIT);
    end
  end

  assign state      = st_q;
  assign fail_count = fail_q;

endmodule
